// File: rtl/mult_seq_shift_add_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// FSM encodings are plain localparams so older blocks can reuse them.
package mult_seq_shift_add_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/mult_seq_shift_add_if.sv
// Request/result bundle between issuing control and the multiplier.
interface mult_seq_shift_add_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  start;
  logic                  op_signed;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic                  busy;
  logic                  done;
  logic [2*DATA_W-1:0]   product;

  modport master (
    output start, op_signed, op_a, op_b,
    input  busy, done, product
  );

  modport slave (
    input  start, op_signed, op_a, op_b,
    output busy, done, product
  );
endinterface

// File: rtl/mult_seq_shift_add_ctrl.sv
// Sequencing FSM and iteration counter for the shift-add multiplier.
// stop_i lets the datapath end RUN early when no multiplier bits remain.
module mult_seq_shift_add_ctrl
  import mult_seq_shift_add_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic clk,
  input  logic arst_n,
  input  logic start_i,
  input  logic stop_i,
  output logic busy_o,
  output logic done_o,
  output logic load_o,
  output logic step_o,
  output logic last_o
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_o  = 1'b0;
    step_o  = 1'b0;
    last_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          load_o  = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step_o = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1) || stop_i) begin
          last_o  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

endmodule

// File: rtl/mult_seq_shift_add_en_reg.sv
// Enabled register with asynchronous active-low clear.
module mult_seq_shift_add_en_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mult_seq_shift_add.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, sign applied at the end.
// Define MULT_SEQ_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module mult_seq_shift_add
  import mult_seq_shift_add_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                 clk,
  input  logic                 arst_n,
  mult_seq_shift_add_if.slave  mul_io
);

  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic                neg_q, neg_d;

  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [2*DATA_W-1:0] acc_sum;
  logic [2*DATA_W-1:0] product_d, product_q;
  logic                load, step, last, stop, busy, done;

  // Magnitude of the most negative value still fits as an unsigned DATA_W word.
  assign abs_a = (mul_io.op_signed && mul_io.op_a[DATA_W-1]) ? (~mul_io.op_a + 1'b1)
                                                             : mul_io.op_a;
  assign abs_b = (mul_io.op_signed && mul_io.op_b[DATA_W-1]) ? (~mul_io.op_b + 1'b1)
                                                             : mul_io.op_b;

  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product_d = neg_q ? (~acc_sum + 1'b1) : acc_sum;

`ifdef MULT_SEQ_EARLY_TERM_EN
  assign stop = (mplier_q[DATA_W-1:1] == '0);
`else
  assign stop = 1'b0;
`endif

  mult_seq_shift_add_ctrl #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_ctrl (
    .clk     (clk),
    .arst_n  (arst_n),
    .start_i (mul_io.start),
    .stop_i  (stop),
    .busy_o  (busy),
    .done_o  (done),
    .load_o  (load),
    .step_o  (step),
    .last_o  (last)
  );

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    if (load) begin
      mcand_d  = {{DATA_W{1'b0}}, abs_a};
      mplier_d = abs_b;
      acc_d    = '0;
      neg_d    = mul_io.op_signed & (mul_io.op_a[DATA_W-1] ^ mul_io.op_b[DATA_W-1]);
    end else if (step) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
    end
  end

  // Loaded on the final RUN edge, i.e. the same edge that enters DONE.
  mult_seq_shift_add_en_reg #(
    .Width (2 * DATA_W)
  ) u_product_reg (
    .clk    (clk),
    .arst_n (arst_n),
    .en_i   (last),
    .d_i    (product_d),
    .q_o    (product_q)
  );

  assign mul_io.busy    = busy;
  assign mul_io.done    = done;
  assign mul_io.product = product_q;

endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Directed and random checks of mult_seq_shift_add against an arithmetic reference model.
module tb_mult_seq_shift_add;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mult_seq_shift_add_if #(.DATA_W(W)) mul_io ();

  mult_seq_shift_add #(.DATA_W(W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .mul_io (mul_io.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Edges after the accept edge until done is visible.
  function automatic int exp_lat(input logic [31:0] b, input bit s);
`ifdef MULT_SEQ_EARLY_TERM_EN
    logic [31:0] m;
    int k;
    m = (s && b[31]) ? (32'd0 - b) : b;
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    return k;
`else
    return W;
`endif
  endfunction

  task automatic scramble();
    mul_io.op_a      = $urandom;
    mul_io.op_b      = $urandom;
    mul_io.op_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit s);
    @(negedge clk);
    chk("idle_busy", {63'd0, mul_io.busy}, 64'd0);
    mul_io.start     = 1'b1;
    mul_io.op_a      = a;
    mul_io.op_b      = b;
    mul_io.op_signed = s;
    @(negedge clk);
    mul_io.start = 1'b0;
    scramble();
  endtask

  task automatic finish_op(input string tag, input logic [63:0] exp_p, input int exp_k);
    int k = 0;
    bit busy_ok = 1'b1;
    while (!mul_io.done && k < 200) begin
      if (!mul_io.busy) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(exp_k));
    chk({tag, "_product"}, mul_io.product, exp_p);
    chk({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, "_busy_done"}, {63'd0, mul_io.busy}, 64'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {63'd0, mul_io.done}, 64'd0);
    chk({tag, "_busy_clear"}, {63'd0, mul_io.busy}, 64'd0);
    chk({tag, "_hold"}, mul_io.product, exp_p);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit s);
    start_op(a, b, s);
    finish_op(tag, model(a, b, s), exp_lat(b, s));
  endtask

  initial begin
    logic [31:0] a, b, a2, b2;
    bit s, s2;
    int k, dones;

    mul_io.start     = 1'b0;
    mul_io.op_signed = 1'b0;
    mul_io.op_a      = '0;
    mul_io.op_b      = '0;
    #12;
    chk("rst_busy", {63'd0, mul_io.busy}, 64'd0);
    chk("rst_done", {63'd0, mul_io.done}, 64'd0);
    chk("rst_product", mul_io.product, 64'd0);
    @(negedge clk);
    arst_n = 1'b1;

    run_op("unsigned", 32'h0000_FFFF, 32'h0001_0001, 1'b0);
    chk("unsigned_value", mul_io.product, 64'h0000_0000_FFFF_FFFF);
    run_op("signed_neg", 32'hFFFF_FFFD, 32'd7, 1'b1);
    chk("signed_value", mul_io.product, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("unsigned_big", 32'hFFFF_FFFD, 32'd7, 1'b0);
    chk("unsigned_big_value", mul_io.product, 64'h0000_0006_FFFF_FFEB);
    run_op("min_min", 32'h8000_0000, 32'h8000_0000, 1'b1);
    chk("min_min_value", mul_io.product, 64'h4000_0000_0000_0000);
    run_op("zero_b", 32'h1234_5678, 32'd0, 1'b0);
    run_op("b_eight", 32'h0000_0123, 32'd8, 1'b1);
    run_op("neg_b", 32'd5, 32'hFFFF_FFF8, 1'b1);

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      run_op("random", a, b, s);
    end

    // start held high through RUN/DONE while operands keep changing
    a = $urandom; b = $urandom; s = 1'b1;
    a2 = $urandom; b2 = $urandom >> 20; s2 = 1'b0;
    @(negedge clk);
    mul_io.start = 1'b1;
    mul_io.op_a = a; mul_io.op_b = b; mul_io.op_signed = s;
    @(negedge clk);
    k = 0;
    while (!mul_io.done && k < 200) begin
      scramble();
      @(negedge clk);
      k++;
    end
    chk("hold_latency", 64'(k), 64'(exp_lat(b, s)));
    chk("hold_product", mul_io.product, model(a, b, s));
    mul_io.op_a = a2; mul_io.op_b = b2; mul_io.op_signed = s2;
    @(negedge clk);
    chk("hold_done_once", {63'd0, mul_io.done}, 64'd0);
    chk("hold_idle_gap", {63'd0, mul_io.busy}, 64'd0);
    @(negedge clk);
    chk("hold_reaccept", {63'd0, mul_io.busy}, 64'd1);
    mul_io.start = 1'b0;
    scramble();
    finish_op("hold_second", model(a2, b2, s2), exp_lat(b2, s2));

    // reset mid-RUN aborts without a done
    start_op(32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
    repeat (9) @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, mul_io.busy}, 64'd0);
    chk("abort_done", {63'd0, mul_io.done}, 64'd0);
    chk("abort_product", mul_io.product, 64'd0);
    @(negedge clk);
    arst_n = 1'b1;
    dones = 0;
    repeat (50) begin
      @(negedge clk);
      if (mul_io.done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    run_op("after_abort", 32'h0000_0003, 32'hFFFF_FFFF, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
